// File: rtl/sipo_pkg.sv
// Shared types and default sizing for the SIPO frame assembler.
package sipo_pkg;

  // Receive state:
  //   IDLE  : no bits held
  //   SHIFT : 1..WIDTH-1 data bits held
  //   PAR   : WIDTH data bits held, waiting for the parity bit
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/sipo_idle_timer.sv
// Idle-cycle timer: counts cycles with run=1 and no clear, and flags the
// cycle that would be the TIMEOUT-th idle cycle. TIMEOUT=0 disables it.
module sipo_idle_timer
  import sipo_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // next idle count: cleared by activity, saturates at TIMEOUT
      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (run && (cnt_q != CW'(TIMEOUT))) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // idle count register
      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      // the current cycle is the TIMEOUT-th consecutive idle one; a clear
      // (accepted bit or resync) on this cycle cancels the abort
      assign expired = run && !clear && (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/sipo_frame_assembler.sv
// Serial-in/parallel-out word assembler with optional even parity,
// idle abort and resync. Feeds a parallel-load shift register.
//
//   state | meaning
//   IDLE  | no bits held
//   SHIFT | 1..WIDTH-1 data bits held
//   PAR   | WIDTH data bits held, waiting for the parity bit
module sipo_frame_assembler
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             load_pulse,
  output logic             parity_err,
  output logic             timeout_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               par_q, par_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               load_q, load_d;
  logic               perr_q, perr_d;
  logic               terr_q, terr_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   shifted;
  logic               expired;
  logic               tmr_clear;
  logic               tmr_run;

  assign tmr_run   = (state_q != IDLE);
  assign tmr_clear = bit_valid || frame_start || (state_q == IDLE);

  sipo_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .run     (tmr_run),
    .expired (expired)
  );

  // shift register contents if the current bit is accepted
  always_comb begin
    if (MSB_FIRST != 0) shifted = {shreg_q[WIDTH-2:0], bit_in};
    else                shifted = {bit_in, shreg_q[WIDTH-1:1]};
  end

  // next state, datapath and strobes; frame_start overrides everything
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    data_d    = data_q;
    load_d    = 1'b0;
    perr_d    = 1'b0;
    terr_d    = 1'b0;

    if (frame_start) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      par_d     = 1'b0;
      if (bit_valid) begin
        // the coincident bit starts the new word
        shreg_d   = shifted;
        bit_cnt_d = CNT_W'(1);
        par_d     = bit_in;
        state_d   = SHIFT;
      end
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          par_d     = 1'b0;
          if (bit_valid) begin
            shreg_d   = shifted;
            bit_cnt_d = CNT_W'(1);
            par_d     = bit_in;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            shreg_d = shifted;
            par_d   = par_q ^ bit_in;
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
              if (PARITY_EN != 0) begin
                bit_cnt_d = CNT_W'(WIDTH);
                state_d   = PAR;
              end else begin
                data_d    = shifted;
                load_d    = 1'b1;
                bit_cnt_d = '0;
                state_d   = IDLE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else if (expired) begin
            terr_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end
        end
        PAR: begin
          if (bit_valid) begin
            if (bit_in == par_q) begin
              data_d = shreg_q;
              load_d = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else if (expired) begin
            terr_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end
        end
        default: begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      endcase
    end
  end

  // busy is registered from the next state so it tracks state_q exactly
  always_comb begin
    busy_d = (state_d != IDLE);
  end

  // state, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      load_q    <= 1'b0;
      perr_q    <= 1'b0;
      terr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      data_q    <= data_d;
      load_q    <= load_d;
      perr_q    <= perr_d;
      terr_q    <= terr_d;
      busy_q    <= busy_d;
    end
  end

  assign data_out    = data_q;
  assign load_pulse  = load_q;
  assign parity_err  = perr_q;
  assign timeout_err = terr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sipo_frame_assembler.sv
// Directed bench for sipo_frame_assembler. Three instances:
//   0: MSB-first, no parity, TIMEOUT=4 (word, timeout, resync, reset)
//   1: LSB-first, no parity, timeout off
//   2: MSB-first, even parity, timeout off
module tb_sipo_frame_assembler;

  logic       clk = 1'b0;
  logic       rst   [3];
  logic       bin   [3];
  logic       bval  [3];
  logic       fs    [3];
  logic [7:0] dout  [3];
  logic       load  [3];
  logic       perr  [3];
  logic       terr  [3];
  logic       busy  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_frame_assembler #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0), .TIMEOUT(4)) u_dut0 (
    .clk(clk), .reset(rst[0]), .bit_in(bin[0]), .bit_valid(bval[0]), .frame_start(fs[0]),
    .data_out(dout[0]), .load_pulse(load[0]), .parity_err(perr[0]),
    .timeout_err(terr[0]), .busy(busy[0]));

  sipo_frame_assembler #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0), .TIMEOUT(0)) u_dut1 (
    .clk(clk), .reset(rst[1]), .bit_in(bin[1]), .bit_valid(bval[1]), .frame_start(fs[1]),
    .data_out(dout[1]), .load_pulse(load[1]), .parity_err(perr[1]),
    .timeout_err(terr[1]), .busy(busy[1]));

  sipo_frame_assembler #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1), .TIMEOUT(0)) u_dut2 (
    .clk(clk), .reset(rst[2]), .bit_in(bin[2]), .bit_valid(bval[2]), .frame_start(fs[2]),
    .data_out(dout[2]), .load_pulse(load[2]), .parity_err(perr[2]),
    .timeout_err(terr[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_bit(input int d, input logic b, input logic f);
    bin[d]  = b;
    bval[d] = 1'b1;
    fs[d]   = f;
    step();
    bval[d] = 1'b0;
    fs[d]   = 1'b0;
  endtask

  // sends the n leading bits of v, v[7] first
  task automatic send_bits(input int d, input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(d, v[7-i], 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; bin[i] = 1'b0; bval[i] = 1'b0; fs[i] = 1'b0;
    end
    idle(2);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    chk("reset_outputs0", {dout[0], load[0], perr[0], terr[0], busy[0]}, 0);
    chk("reset_outputs2", {dout[2], load[2], perr[2], terr[2], busy[2]}, 0);

    // MSB-first 0xA5
    send_bit(0, 1'b1, 1'b0);
    chk("busy_after_first_bit", busy[0], 1);
    send_bits(0, 8'b0100_1010, 7);
    chk("msb_data", dout[0], 8'hA5);
    chk("msb_load", load[0], 1);
    chk("msb_busy_low", busy[0], 0);
    step();
    chk("msb_load_one_cycle", load[0], 0);
    chk("msb_data_held", dout[0], 8'hA5);

    // LSB-first: 1,0,1,0,0,1,0,1 -> 0xA5 then 1,1,0,0,0,0,0,0 -> 0x03
    send_bits(1, 8'b1010_0101, 8);
    chk("lsb_data_a5", dout[1], 8'hA5);
    chk("lsb_load_a5", load[1], 1);
    send_bits(1, 8'b1100_0000, 8);
    chk("lsb_data_03", dout[1], 8'h03);
    chk("lsb_load_03", load[1], 1);

    // parity: 0xA5 + 0 loads, back-to-back 0x3C + 1 errors
    send_bits(2, 8'hA5, 8);
    chk("par_no_early_load", load[2], 0);
    chk("par_busy_in_par", busy[2], 1);
    send_bit(2, 1'b0, 1'b0);
    chk("par_good_data", dout[2], 8'hA5);
    chk("par_good_load", load[2], 1);
    chk("par_good_noerr", perr[2], 0);
    send_bits(2, 8'h3C, 8);
    send_bit(2, 1'b1, 1'b0);
    chk("par_bad_err", perr[2], 1);
    chk("par_bad_noload", load[2], 0);
    chk("par_bad_data_kept", dout[2], 8'hA5);
    chk("par_bad_busy", busy[2], 0);
    step();
    chk("par_err_one_cycle", perr[2], 0);

    // timeout after 4 idle cycles, then clean 0xFF
    send_bits(0, 8'b1010_0000, 3);
    idle(3);
    chk("to_not_yet", {terr[0], busy[0]}, 2'b01);
    step();
    chk("to_fired", {terr[0], busy[0], load[0]}, 3'b100);
    step();
    chk("to_one_cycle", terr[0], 0);
    send_bits(0, 8'hFF, 8);
    chk("to_clean_data", dout[0], 8'hFF);
    chk("to_clean_load", load[0], 1);

    // valid bit on the 4th idle cycle wins over the abort
    send_bits(0, 8'b0000_0000, 3);
    idle(3);
    send_bit(0, 1'b0, 1'b0);
    chk("to_bit_wins", {terr[0], busy[0]}, 2'b01);
    send_bits(0, 8'b0110_0000, 4);
    chk("to_bit_wins_data", dout[0], 8'h06);
    chk("to_bit_wins_load", load[0], 1);

    // resync: 5 bits, frame_start with bit 1, 7 more bits -> 0x81
    send_bits(0, 8'b1111_1000, 5);
    send_bit(0, 1'b1, 1'b1);
    chk("rs_no_load", {load[0], busy[0]}, 2'b01);
    send_bits(0, 8'b0000_0010, 7);
    chk("rs_data", dout[0], 8'h81);
    chk("rs_load", load[0], 1);

    // frame_start on the 8th bit -> no load
    send_bits(0, 8'hFF, 7);
    send_bit(0, 1'b1, 1'b1);
    chk("rs_final_no_load", load[0], 0);
    chk("rs_final_data_kept", dout[0], 8'h81);

    // reset mid-word, then 0x5A
    send_bits(0, 8'b1010_1000, 6);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("rst_mid_outputs", {dout[0], load[0], perr[0], terr[0], busy[0]}, 0);
    send_bits(0, 8'h5A, 8);
    chk("rst_after_data", dout[0], 8'h5A);
    chk("rst_after_load", load[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
